// File: rtl/lut5_cfg_writer.sv
// Runtime configuration writer for a 5-input LUT.
// A 32-bit truth table is shifted in MSB first into a shadow register, one bit per
// valid/ready beat, then copied to the active table in a single edge. The LUT output
// is evaluated combinationally from the active table only, so a partially loaded
// table is never visible on O5 or table_q.
module lut5_cfg_writer #(
    parameter logic [31:0] INIT5 = 32'h0000_0000,
    parameter int unsigned CNT_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic        load_abort,
    input  logic        cfg_valid,
    input  logic        cfg_din,
    output logic        cfg_ready,
    output logic        busy,
    output logic        done,
    input  logic        I0,
    input  logic        I1,
    input  logic        I2,
    input  logic        I3,
    input  logic        I4,
    output logic        O5,
    output logic [31:0] table_q
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCommit
    } state_e;

    localparam logic [CNT_W-1:0] LastBeat = CNT_W'(31);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        shadow_q, shadow_d;
    logic [31:0]        active_q, active_d;
    logic               done_q, done_d;
    logic [4:0]         lut_sel;

    // State register; rst discards any partial load and suppresses done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= INIT5;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic for the load sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        active_d = active_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (load_start) begin
                    state_d  = StShift;
                    cnt_d    = '0;
                    shadow_d = '0;
                end
            end
            StShift: begin
                // Abort wins over a coincident beat: that beat is dropped.
                if (load_abort) begin
                    state_d = StIdle;
                end else if (cfg_valid) begin
                    shadow_d = {shadow_q[30:0], cfg_din};
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == LastBeat) begin
                        state_d = StCommit;
                    end
                end
            end
            StCommit: begin
                active_d = shadow_q;
                done_d   = 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Handshake/status outputs and the combinational LUT read from the active table.
    always_comb begin
        cfg_ready = (state_q == StShift);
        busy      = (state_q != StIdle);
        done      = done_q;
        table_q   = active_q;
        lut_sel   = {I4, I3, I2, I1, I0};
        O5        = active_q[lut_sel];
    end

endmodule

// File: doc/lut5_cfg_writer.md
Name: lut5_cfg_writer

Overview:
- Runtime configuration writer for a 5-input LUT used in the multiplier datapath.
- Loads a new 32-bit truth table serially, one bit per handshake beat, MSB first, into a shadow register.
- Commits the full table atomically to the active table. The LUT output therefore never shows a half-written table.
- The LUT is evaluated combinationally from the active table: O5 = table[{I4,I3,I2,I1,I0}].

Parameters:
- INIT5, 32'h0000_0000, active truth table value at reset. Bit k is the output for input index k = {I4,I3,I2,I1,I0}.
- CNT_W, 5, width of the beat counter. Fixed at log2(32); not intended to be overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- load_start  input  1  one-cycle request to begin a new table load
- load_abort  input  1  cancel the load in progress; active table unchanged
- cfg_valid  input  1  cfg_din holds a valid config bit
- cfg_din  input  1  serial config bit, MSB (table bit 31) first
- cfg_ready  output  1  writer accepts a bit this cycle
- busy  output  1  load in progress (state SHIFT or COMMIT)
- done  output  1  one-cycle pulse: new table is now active
- I0..I4  input  1 each  LUT select inputs, I0 = LSB
- O5  output  1  combinational LUT output from the active table
- table_q  output  32  active table readback

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, active=INIT5, shadow=0, cnt=0.
  - Outputs: cfg_ready=0, busy=0, done=0, table_q=INIT5.
  - O5 immediately follows INIT5.
  - rst has priority over every other input, including mid-load. A partial shadow is discarded and no done pulse is produced.
- States: IDLE, SHIFT, COMMIT. State outputs: cfg_ready=1 only in SHIFT; busy=1 in SHIFT and COMMIT.
- IDLE:
  - load_start=1 -> SHIFT, with cnt<=0 and shadow<=0.
  - cfg_valid and load_abort are ignored.
- SHIFT:
  - A beat is accepted when cfg_valid & cfg_ready. On acceptance: shadow<={shadow[30:0],cfg_din}, cnt<=cnt+1.
  - cfg_valid=0 stalls; cnt and shadow hold.
  - Accepted beat with cnt==31 -> COMMIT; cnt wraps to 0.
  - load_abort=1 -> IDLE with no commit and no done. Abort beats a simultaneous beat: that beat is not accepted.
  - load_start while in SHIFT is ignored; it does not restart the count.
- COMMIT (exactly one cycle):
  - cfg_ready=0; load_abort is ignored.
  - At the closing edge: active<=shadow, done<=1, state<=IDLE.
- done:
  - Registered; high for exactly one cycle, in the first IDLE cycle after COMMIT.
  - Coincides with the first cycle in which table_q and O5 reflect the new table.
- Latency:
  - load_start sampled at edge E0 -> cfg_ready=1 from cycle E0+1.
  - With cfg_valid held high: final beat accepted at edge E0+32, COMMIT during the following cycle, done=1 and new table visible after edge E0+33.
- Back-to-back loads: load_start asserted during the done cycle (IDLE) starts a new load immediately.
- O5 and table_q:
  - Purely combinational from active; zero latency from I0..I4.
  - Unaffected by shadow contents during SHIFT.

Test Plan:
- Reset with INIT5=32'hCA00_CA00 -> table_q=32'hCA00_CA00; I=5'b01001 gives O5=1, I=5'b00000 gives O5=0; cfg_ready=0, busy=0, done=0.
- load_start, then 32 beats of 32'h8000_0001 MSB first with cfg_valid held high -> done pulses exactly 33 cycles after load_start was sampled; table_q=32'h8000_0001; O5=1 only for I=0 and I=31.
- Same load with cfg_valid deasserted for 3 cycles after beat 10 -> cnt holds at 11; final table_q=32'h8000_0001; done delayed by exactly 3 cycles.
- Load of 32'hFFFF_FFFF aborted after 20 beats, with load_abort and cfg_valid asserted together -> back to IDLE, no done; table_q unchanged; a following full load of 32'h0F0F_0F0F commits correctly.
- rst asserted after 16 beats -> table_q=INIT5, busy=0, no done pulse; a new load after reset completes normally.
- Throughout a load, sweep I0..I4 during SHIFT -> O5 matches the old table every cycle; after done it matches the new table. A second load_start during SHIFT has no effect on cnt.
